// File: rtl/multi_sat_counter_if.sv
// Bundle of control, configuration and status signals for multi_sat_counter.
// Optional sticky-flag signals exist only when MULTI_SAT_COUNTER_STICKY_EN is defined.
interface multi_sat_counter_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int STEP_W = 3
);
  logic [NUM_CH-1:0]        clear;
  logic [NUM_CH-1:0]        load;
  logic [NUM_CH*WIDTH-1:0]  load_val;
  logic [NUM_CH-1:0]        enable;
  logic [NUM_CH-1:0]        up_down_n;
  logic [NUM_CH*STEP_W-1:0] step_size;
  logic                     wrap_mode;
  logic [WIDTH-1:0]         count_min;
  logic [WIDTH-1:0]         count_max;
  logic [NUM_CH*WIDTH-1:0]  count;
  logic [NUM_CH-1:0]        max_reached;
  logic [NUM_CH-1:0]        min_reached;
  logic [NUM_CH-1:0]        bound_event;
`ifdef MULTI_SAT_COUNTER_STICKY_EN
  logic [NUM_CH-1:0]        sticky_clr;
  logic [NUM_CH-1:0]        bound_sticky;
`endif

  modport master (
    output clear, load, load_val, enable, up_down_n, step_size,
           wrap_mode, count_min, count_max,
`ifdef MULTI_SAT_COUNTER_STICKY_EN
    output sticky_clr,
    input  bound_sticky,
`endif
    input  count, max_reached, min_reached, bound_event
  );

  modport slave (
    input  clear, load, load_val, enable, up_down_n, step_size,
           wrap_mode, count_min, count_max,
`ifdef MULTI_SAT_COUNTER_STICKY_EN
    input  sticky_clr,
    output bound_sticky,
`endif
    output count, max_reached, min_reached, bound_event
  );
endinterface

// File: rtl/multi_sat_counter.sv
// Bank of independent up/down counters with a shared [min,max] window, saturate or wrap.
// Define MULTI_SAT_COUNTER_STICKY_EN to add per-channel sticky boundary flags.
module multi_sat_counter #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int STEP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  multi_sat_counter_if.slave  bus
);

  logic cfgOk;
  assign cfgOk = (bus.count_min <= bus.count_max);

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    logic [WIDTH-1:0] count_q, count_d;
    logic             event_q, event_d;
    logic [WIDTH-1:0] base, loadVal;
    logic [WIDTH:0]   step_w, sum_w, lowLimit_w;

    assign loadVal    = bus.load_val[i*WIDTH +: WIDTH];
    assign step_w     = (WIDTH+1)'(bus.step_size[i*STEP_W +: STEP_W]) + (WIDTH+1)'(1);
    assign sum_w      = {1'b0, base} + step_w;
    assign lowLimit_w = {1'b0, bus.count_min} + step_w;

    // Bounds may move at run time, so snap the count into the window before stepping.
    always_comb begin
      base = count_q;
      if (count_q < bus.count_min)
        base = bus.count_min;
      else if (count_q > bus.count_max)
        base = bus.count_max;
    end

    always_comb begin
      count_d = count_q;
      event_d = 1'b0;
      if (bus.clear[i]) begin
        count_d = bus.count_min;
      end else if (cfgOk) begin
        if (bus.load[i]) begin
          if (loadVal < bus.count_min) begin
            count_d = bus.count_min;
            event_d = 1'b1;
          end else if (loadVal > bus.count_max) begin
            count_d = bus.count_max;
            event_d = 1'b1;
          end else begin
            count_d = loadVal;
          end
        end else if (bus.enable[i]) begin
          if (bus.up_down_n[i]) begin
            if (sum_w <= {1'b0, bus.count_max}) begin
              count_d = sum_w[WIDTH-1:0];
            end else begin
              count_d = bus.wrap_mode ? bus.count_min : bus.count_max;
              event_d = 1'b1;
            end
          end else begin
            // base >= min + step guarantees step fits in WIDTH bits here.
            if ({1'b0, base} >= lowLimit_w) begin
              count_d = base - step_w[WIDTH-1:0];
            end else begin
              count_d = bus.wrap_mode ? bus.count_max : bus.count_min;
              event_d = 1'b1;
            end
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q <= '0;
        event_q <= 1'b0;
      end else begin
        count_q <= count_d;
        event_q <= event_d;
      end
    end

    assign bus.count[i*WIDTH +: WIDTH] = count_q;
    assign bus.bound_event[i]          = event_q;
    assign bus.max_reached[i]          = (count_q == bus.count_max);
    assign bus.min_reached[i]          = (count_q == bus.count_min);

`ifdef MULTI_SAT_COUNTER_STICKY_EN
    logic sticky_q, sticky_d;

    // A new boundary event wins over a coincident clear request.
    always_comb begin
      sticky_d = event_d | (sticky_q & ~bus.sticky_clr[i]);
    end

    always_ff @(posedge clk) begin
      if (rst)
        sticky_q <= 1'b0;
      else
        sticky_q <= sticky_d;
    end

    assign bus.bound_sticky[i] = sticky_q;
`endif
  end

endmodule

// File: tb/tb_multi_sat_counter.sv
// Directed testbench for multi_sat_counter with hand-computed expected values.
// Sticky checks run only when MULTI_SAT_COUNTER_STICKY_EN is defined.
module tb_multi_sat_counter;
  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  multi_sat_counter_if #(.WIDTH(8), .NUM_CH(4), .STEP_W(3)) bus ();

  multi_sat_counter #(.WIDTH(8), .NUM_CH(4), .STEP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the given number of rising edges and settle just after the last one.
  task automatic applyStimulus(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [7:0] chCount(input int ch);
    return bus.count[ch*8 +: 8];
  endfunction

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    bus.clear = '0;
    bus.load = '0;
    bus.load_val = '0;
    bus.enable = 4'hF;
    bus.up_down_n = 4'hF;
    bus.step_size = '0;
    bus.wrap_mode = 1'b0;
    bus.count_min = 8'd0;
    bus.count_max = 8'd20;
`ifdef MULTI_SAT_COUNTER_STICKY_EN
    bus.sticky_clr = '0;
`endif

    // Reset with all channels enabled
    applyStimulus(2);
    checkOutput("reset_count", bus.count, 32'h0);
    checkOutput("reset_event", {28'h0, bus.bound_event}, 32'h0);
    checkOutput("reset_min_reached", {28'h0, bus.min_reached}, 32'hF);
`ifdef MULTI_SAT_COUNTER_STICKY_EN
    checkOutput("reset_sticky", {28'h0, bus.bound_sticky}, 32'h0);
`endif

    // Saturating count up on ch0, step 1
    rst = 1'b0;
    bus.enable = 4'b0001;
    for (int c = 1; c <= 25; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("satup_count_c%0d", c), {24'h0, chCount(0)},
                  (c > 20) ? 32'd20 : 32'(c));
      checkOutput($sformatf("satup_event_c%0d", c), {31'h0, bus.bound_event[0]},
                  (c > 20) ? 32'd1 : 32'd0);
    end
    checkOutput("satup_max_reached", {28'h0, bus.max_reached}, 32'b0001);
    checkOutput("satup_others_hold", {8'h0, bus.count[31:8]}, 32'h0);

    // Wrap up on ch1: load 18, step 4, window [5,20]
    bus.enable = 4'b0000;
    bus.wrap_mode = 1'b1;
    bus.count_min = 8'd5;
    bus.load = 4'b0010;
    bus.load_val[15:8] = 8'd18;
    applyStimulus(1);
    checkOutput("wrap_load", {24'h0, chCount(1)}, 32'd18);
    checkOutput("wrap_load_event", {28'h0, bus.bound_event}, 32'h0);
    bus.load = 4'b0000;
    bus.enable = 4'b0010;
    bus.step_size[5:3] = 3'd3;
    applyStimulus(1);
    checkOutput("wrap_to_min", {24'h0, chCount(1)}, 32'd5);
    checkOutput("wrap_event", {28'h0, bus.bound_event}, 32'b0010);
    applyStimulus(1);
    checkOutput("wrap_step2", {24'h0, chCount(1)}, 32'd9);
    checkOutput("wrap_step2_event", {28'h0, bus.bound_event}, 32'h0);
    applyStimulus(1);
    checkOutput("wrap_step3", {24'h0, chCount(1)}, 32'd13);
    checkOutput("ch0_hold", {24'h0, chCount(0)}, 32'd20);

    // Saturating count down on ch2: load 10, step 8, window [0,20]
    bus.enable = 4'b0000;
    bus.wrap_mode = 1'b0;
    bus.count_min = 8'd0;
    bus.load = 4'b0100;
    bus.load_val[23:16] = 8'd10;
    applyStimulus(1);
    checkOutput("down_load", {24'h0, chCount(2)}, 32'd10);
    bus.load = 4'b0000;
    bus.enable = 4'b0100;
    bus.up_down_n = 4'b1011;
    bus.step_size[8:6] = 3'd7;
    applyStimulus(1);
    checkOutput("down_step", {24'h0, chCount(2)}, 32'd2);
    checkOutput("down_step_event", {28'h0, bus.bound_event}, 32'h0);
    applyStimulus(1);
    checkOutput("down_sat", {24'h0, chCount(2)}, 32'd0);
    checkOutput("down_sat_event", {28'h0, bus.bound_event}, 32'b0100);
    applyStimulus(1);
    checkOutput("down_sat_again", {24'h0, chCount(2)}, 32'd0);
    checkOutput("down_sat_again_event", {28'h0, bus.bound_event}, 32'b0100);
    checkOutput("down_min_reached", {31'h0, bus.min_reached[2]}, 32'd1);

    // Priority and load clamping on ch3, window [5,20]
    bus.up_down_n = 4'hF;
    bus.count_min = 8'd5;
    bus.clear = 4'b1000;
    bus.load = 4'b1000;
    bus.enable = 4'b1000;
    bus.load_val[31:24] = 8'd200;
    applyStimulus(1);
    checkOutput("prio_clear", {24'h0, chCount(3)}, 32'd5);
    checkOutput("prio_clear_event", {28'h0, bus.bound_event}, 32'h0);
    checkOutput("ch2_hold_below_min", {24'h0, chCount(2)}, 32'd0);
    bus.clear = 4'b0000;
    bus.enable = 4'b0000;
    applyStimulus(1);
    checkOutput("clamp_high", {24'h0, chCount(3)}, 32'd20);
    checkOutput("clamp_high_event", {28'h0, bus.bound_event}, 32'b1000);
    bus.load_val[31:24] = 8'd2;
    applyStimulus(1);
    checkOutput("clamp_low", {24'h0, chCount(3)}, 32'd5);
    checkOutput("clamp_low_event", {28'h0, bus.bound_event}, 32'b1000);
    bus.load = 4'b0000;
    applyStimulus(1);
    checkOutput("hold_event_clears", {28'h0, bus.bound_event}, 32'h0);

    // Illegal window: enable and load ignored, clear still applies
    bus.count_min = 8'd30;
    bus.count_max = 8'd20;
    bus.enable = 4'hF;
    bus.load = 4'b0001;
    bus.load_val[7:0] = 8'd7;
    applyStimulus(1);
    checkOutput("illegal_hold", bus.count, {8'd5, 8'd0, 8'd13, 8'd20});
    checkOutput("illegal_event", {28'h0, bus.bound_event}, 32'h0);
    bus.load = 4'b0000;
    bus.clear = 4'b0100;
    applyStimulus(1);
    checkOutput("illegal_clear", bus.count, {8'd5, 8'd30, 8'd13, 8'd20});
    checkOutput("illegal_clear_event", {28'h0, bus.bound_event}, 32'h0);

`ifdef MULTI_SAT_COUNTER_STICKY_EN
    // Sticky flags: hold after event, set wins over coincident clear
    bus.clear = 4'b0000;
    bus.enable = 4'b0000;
    bus.count_min = 8'd0;
    bus.count_max = 8'd20;
    bus.sticky_clr = 4'hF;
    applyStimulus(1);
    checkOutput("sticky_cleared", {28'h0, bus.bound_sticky}, 32'h0);
    bus.sticky_clr = 4'h0;
    bus.enable = 4'b0001;
    applyStimulus(1);
    checkOutput("sticky_set", {28'h0, bus.bound_sticky}, 32'b0001);
    bus.enable = 4'b0000;
    applyStimulus(2);
    checkOutput("sticky_holds", {28'h0, bus.bound_sticky}, 32'b0001);
    checkOutput("sticky_holds_event", {28'h0, bus.bound_event}, 32'h0);
    bus.enable = 4'b0001;
    bus.sticky_clr = 4'b0001;
    applyStimulus(1);
    checkOutput("sticky_set_wins", {28'h0, bus.bound_sticky}, 32'b0001);
    bus.enable = 4'b0000;
    applyStimulus(1);
    checkOutput("sticky_clr", {28'h0, bus.bound_sticky}, 32'h0);
    bus.sticky_clr = 4'h0;
`endif

    // Reset in the middle of operation
    bus.clear = 4'b0000;
    bus.count_min = 8'd0;
    bus.count_max = 8'd20;
    bus.enable = 4'hF;
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("midreset_count", bus.count, 32'h0);
    checkOutput("midreset_event", {28'h0, bus.bound_event}, 32'h0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
